gray_conv_arbiter: RTL
======================

Name: gray_conv_arbiter

Overview:
- Shares one binary-to-Gray conversion datapath between two requesters, using round-robin arbitration and a req/gnt handshake.
- A 3-state FSM sequences each job: latch operand, convert into a registered result, return the result with a grant pulse.
- Sits between lab-cycle stimulus sources and the combinational Gray converter. Adds serialisation and fairness, so converter output is registered and attributable to exactly one requester.

Parameters:
- WIDTH, 4, bit width of binary operands and Gray results (must be >= 2).

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 conversion request (level; held until gnt0).
- din0  input  WIDTH  requester 0 binary operand; stable while req0 high.
- req1  input  1  requester 1 conversion request (level; held until gnt1).
- din1  input  WIDTH  requester 1 binary operand; stable while req1 high.
- gnt0  output  1  one-cycle pulse: requester 0 job complete, dout valid for it.
- gnt1  output  1  one-cycle pulse: requester 1 job complete, dout valid for it.
- dout  output  WIDTH  registered Gray result; holds last value between jobs.
- dout_valid  output  1  high exactly in the cycle gnt0 or gnt1 is high.
- dout_id  output  1  owner of current/last result (0 or 1).
- busy  output  1  high in CONV and DONE states.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; gnt0=gnt1=0; dout_valid=0; dout=0; dout_id=0; busy=0; operand reg=0; rr pointer=0 (requester 0 has priority first).
- Reset mid-operation aborts the job immediately. No grant is issued. The requester must still be holding req after reset and is re-served.
- FSM states IDLE, CONV, DONE:
  - IDLE: if neither req, stay. If exactly one req, select it. If both req, select the one not equal to last_served (rr pointer). Latch selected din into operand reg and its index into owner reg. Go to CONV.
  - CONV: dout <= operand ^ (operand >> 1). In bit terms: MSB passes through, bit i = op[i+1]^op[i]. dout_id <= owner. Go to DONE.
  - DONE: drive gnt[owner]=1 and dout_valid=1 for this single cycle. last_served <= owner. Go to IDLE.
- Outputs gnt*, dout_valid and busy are registered (decoded from state/owner flops, no input-to-output combinational path).
- Latency: req sampled in IDLE at edge T; grant/dout_valid high in cycle T+2. Max throughput is one job per 3 cycles.
- Requester handshake: hold req and din until the cycle gnt is seen high. Drop req on the edge after gnt, or keep it high to request a new job, which is then eligible at the next IDLE cycle.
- Fairness: with both reqs continuously high, grants strictly alternate 0,1,0,1.
- req dropped after operand latch: job still completes and grant still pulses. din changes after latch are ignored.
- No req arriving in IDLE: dout and dout_id hold their values indefinitely.
- WIDTH arithmetic: shift is logical (zero-fill MSB). No overflow is possible.

Test Plan:
- Reset then req0=1, din0=4'b0010, edge T -> gnt0=1, dout_valid=1, dout=4'b0011, dout_id=0 at T+2; busy high at T+1..T+2.
- req1 only, din1=4'b0111 -> gnt1 pulse with dout=4'b0100, dout_id=1, after 2 cycles; gnt0 stays 0.
- req0 and req1 both held high, din0=4'b1111, din1=4'b1010 -> grants alternate 0,1,0,1 every 3 cycles; dout alternates 4'b1000 / 4'b1111.
- req0 dropped and din0 changed to 4'b0000 the cycle after latch of din0=4'b0101 -> gnt0 still pulses with dout=4'b0111.
- rst_n pulsed low during CONV -> all outputs immediately 0 and state IDLE. Held req1 (din1=4'b1000) is served afterwards: dout=4'b1100.
- Exhaustive sweep of din0 = 0..15 -> each dout equals b^(b>>1) and dout_valid is a single-cycle pulse per job.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - round-robin shared binary-to-Gray converter
module gray_conv_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] operand;
    logic             owner;
    logic             prio;
    logic             sel_valid;
    logic             sel_id;

    // prio names the requester that wins a tie; it flips away from whoever was just served.
    always_comb begin
        sel_valid = req0 | req1;
        sel_id    = 1'b0;
        if (req0 && req1) begin
            sel_id = prio;
        end else if (req1) begin
            sel_id = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_valid) state_next = CONV;
            CONV:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= '0;
            owner   <= 1'b0;
            prio    <= 1'b0;
            dout    <= '0;
            dout_id <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        operand <= sel_id ? din1 : din0;
                        owner   <= sel_id;
                    end
                end
                CONV: begin
                    dout    <= operand ^ (operand >> 1);
                    dout_id <= owner;
                end
                DONE: begin
                    prio <= ~owner;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are flopped one state ahead so they line up with DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt0       <= (state == CONV) && !owner;
            gnt1       <= (state == CONV) && owner;
            dout_valid <= (state == CONV);
            busy       <= (state_next != IDLE);
        end
    end

endmodule
